// File: rtl/digest_match.sv
// digest_match
//   Collects 5-word SHA-1 digests from a word stream. The first two words of
//   each digest are compared against a masked target. Digests that match are
//   queued, together with their burst index, in a small hit FIFO.
//
// Ports
//   clk        : sole clock, rising edge
//   rst_n      : synchronous active-low reset
//   din        : digest word stream, word 0 first, 0 outside bursts
//   din_first  : marks the cycle carrying word 0 of a burst
//   target     : compare value for words 0..1 (word 0 in [63:32])
//   mask       : compare mask, 1 = bit must equal target
//   hit_valid  : FIFO head holds a hit
//   hit_ready  : consumer takes the head on hit_valid & hit_ready
//   hit_digest : head digest, word 0 in [159:128]
//   hit_index  : index of the burst that produced the head entry
//   overflow   : sticky, a hit was dropped on a full FIFO
//   frame_err  : sticky, din_first arrived in the middle of a burst
module digest_match #(
    parameter int FIFO_DEPTH = 4,
    parameter int INDEX_W    = 32
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [31:0]        din,
    input  logic               din_first,
    input  logic [63:0]        target,
    input  logic [63:0]        mask,
    output logic               hit_valid,
    input  logic               hit_ready,
    output logic [159:0]       hit_digest,
    output logic [INDEX_W-1:0] hit_index,
    output logic               overflow,
    output logic               frame_err
);

    localparam int AW = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        COLLECT1,
        COLLECT2,
        COLLECT3,
        COLLECT4
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               burst_done;
    logic               burst_abort;
    logic [31:0]        word_q [0:3];
    logic [INDEX_W-1:0] burst_cnt;

    logic               vld_p0;
    logic [159:0]       digest_p0;
    logic [INDEX_W-1:0] index_p0;
    logic [63:0]        target_p0;
    logic [63:0]        mask_p0;

    logic               vld_p1;
    logic [159:0]       digest_p1;
    logic [INDEX_W-1:0] index_p1;

    logic [159:0]       dig_mem [0:FIFO_DEPTH-1];
    logic [INDEX_W-1:0] idx_mem [0:FIFO_DEPTH-1];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               fifo_full;
    logic               pop;
    logic               push;

    function automatic logic digest_hit(input logic [63:0] head,
                                        input logic [63:0] tgt,
                                        input logic [63:0] msk);
        return ((head ^ tgt) & msk) == 64'd0;
    endfunction

    // Collector: din_first always restarts a burst, even mid-burst
    always_comb begin
        state_nxt   = state;
        burst_done  = 1'b0;
        burst_abort = 1'b0;
        if (din_first) begin
            state_nxt   = COLLECT1;
            burst_abort = (state != IDLE);
        end else begin
            case (state)
                COLLECT1: state_nxt = COLLECT2;
                COLLECT2: state_nxt = COLLECT3;
                COLLECT3: state_nxt = COLLECT4;
                COLLECT4: begin
                    state_nxt  = IDLE;
                    burst_done = 1'b1;
                end
                default:  state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            burst_cnt <= '0;
            frame_err <= 1'b0;
        end else begin
            state <= state_nxt;
            if (burst_done) begin
                burst_cnt <= burst_cnt + INDEX_W'(1);
            end
            if (burst_abort) begin
                frame_err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (din_first) begin
            word_q[0] <= din;
        end else begin
            case (state)
                COLLECT1: word_q[1] <= din;
                COLLECT2: word_q[2] <= din;
                COLLECT3: word_q[3] <= din;
                default:  ;
            endcase
        end
    end

    // Stage p0: completed digest plus the target/mask seen alongside word 4
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
        end else begin
            vld_p0 <= burst_done;
        end
    end

    always_ff @(posedge clk) begin
        if (burst_done) begin
            digest_p0 <= {word_q[0], word_q[1], word_q[2], word_q[3], din};
            index_p0  <= burst_cnt;
            target_p0 <= target;
            mask_p0   <= mask;
        end
    end

    // Stage p1: registered compare result, qualifies the FIFO push
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= vld_p0 && digest_hit(digest_p0[159:96], target_p0, mask_p0);
        end
    end

    always_ff @(posedge clk) begin
        digest_p1 <= digest_p0;
        index_p1  <= index_p0;
    end

    // Hit FIFO: a push into a full FIFO survives only if the head leaves
    assign hit_valid = (count != '0);
    assign fifo_full = (count == FULL_CNT);
    assign pop       = hit_valid && hit_ready;
    assign push      = vld_p1 && (!fifo_full || pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (push && !pop) begin
                count <= count + (AW+1)'(1);
            end else if (pop && !push) begin
                count <= count - (AW+1)'(1);
            end
            if (vld_p1 && fifo_full && !pop) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dig_mem[wr_ptr] <= digest_p1;
            idx_mem[wr_ptr] <= index_p1;
        end
    end

    // Storage is not reset; an empty FIFO presents zeros instead
    assign hit_digest = hit_valid ? dig_mem[rd_ptr] : '0;
    assign hit_index  = hit_valid ? idx_mem[rd_ptr] : '0;

endmodule

// File: tb/tb_digest_match.sv
// tb_digest_match
//   Directed bench for digest_match. A queue-based model of the collector,
//   the two-cycle compare latency and the hit FIFO is compared against the
//   DUT on every negative clock edge. Literal expectations pin the model.
module tb_digest_match;

    localparam int FIFO_DEPTH = 4;
    localparam int INDEX_W    = 32;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [31:0]        din;
    logic               din_first;
    logic [63:0]        target;
    logic [63:0]        mask;
    logic               hit_valid;
    logic               hit_ready;
    logic [159:0]       hit_digest;
    logic [INDEX_W-1:0] hit_index;
    logic               overflow;
    logic               frame_err;

    always #5 clk = ~clk;

    digest_match #(
        .FIFO_DEPTH(FIFO_DEPTH),
        .INDEX_W   (INDEX_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .din       (din),
        .din_first (din_first),
        .target    (target),
        .mask      (mask),
        .hit_valid (hit_valid),
        .hit_ready (hit_ready),
        .hit_digest(hit_digest),
        .hit_index (hit_index),
        .overflow  (overflow),
        .frame_err (frame_err)
    );

    typedef struct {
        logic [159:0]       digest;
        logic [INDEX_W-1:0] index;
    } hit_t;

    typedef struct {
        int                 due;
        logic               hit;
        logic [159:0]       digest;
        logic [INDEX_W-1:0] index;
    } pend_t;

    hit_t               m_q[$];
    pend_t              m_pend[$];
    logic [31:0]        m_words[$];
    logic [INDEX_W-1:0] m_cnt   = '0;
    logic               m_ovf   = 1'b0;
    logic               m_ferr  = 1'b0;
    logic               m_pushed = 1'b0;
    int                 cyc     = 0;
    logic               m_pop;
    logic               m_full;
    pend_t              m_e;
    hit_t               m_h;
    logic [159:0]       m_d;

    int errors = 0;
    int checks = 0;

    // Reference model: a burst is complete on its fifth word; its hit
    // reaches the FIFO two edges later.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_q.delete();
            m_pend.delete();
            m_words.delete();
            m_cnt    = '0;
            m_ovf    = 1'b0;
            m_ferr   = 1'b0;
            m_pushed = 1'b0;
        end else begin
            m_pop  = (m_q.size() > 0) && hit_ready;
            m_full = (m_q.size() == FIFO_DEPTH);
            if (m_pop) void'(m_q.pop_front());
            while (m_pend.size() > 0 && m_pend[0].due == cyc) begin
                m_e = m_pend.pop_front();
                if (m_e.hit) begin
                    if (!m_full || m_pop) begin
                        m_h.digest = m_e.digest;
                        m_h.index  = m_e.index;
                        m_q.push_back(m_h);
                        m_pushed = 1'b1;
                    end else begin
                        m_ovf = 1'b1;
                    end
                end
            end
            if (din_first) begin
                if (m_words.size() > 0) m_ferr = 1'b1;
                m_words.delete();
                m_words.push_back(din);
            end else if (m_words.size() > 0) begin
                m_words.push_back(din);
                if (m_words.size() == 5) begin
                    m_d = {m_words[0], m_words[1], m_words[2], m_words[3], m_words[4]};
                    m_e.due    = cyc + 2;
                    m_e.hit    = (((m_d[159:96] ^ target) & mask) == 64'd0);
                    m_e.digest = m_d;
                    m_e.index  = m_cnt;
                    m_pend.push_back(m_e);
                    m_cnt = m_cnt + 1;
                    m_words.delete();
                end
            end
        end
        cyc++;
    end

    task automatic check(input string name, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic compare();
        check("hit_valid", 160'(hit_valid), 160'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            check("hit_digest", hit_digest, m_q[0].digest);
            check("hit_index", 160'(hit_index), 160'(m_q[0].index));
        end else if (!m_pushed) begin
            check("hit_digest_zero", hit_digest, 160'd0);
            check("hit_index_zero", 160'(hit_index), 160'd0);
        end
        check("overflow", 160'(overflow), 160'(m_ovf));
        check("frame_err", 160'(frame_err), 160'(m_ferr));
    endtask

    task automatic tick(input logic f, input logic [31:0] d);
        @(negedge clk);
        compare();
        din_first = f;
        din       = d;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 32'd0);
    endtask

    task automatic burst(input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                         input logic [31:0] w3, input logic [31:0] w4);
        tick(1'b1, w0);
        tick(1'b0, w1);
        tick(1'b0, w2);
        tick(1'b0, w3);
        tick(1'b0, w4);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n     = 1'b0;
        din       = 32'd0;
        din_first = 1'b0;
        target    = 64'd0;
        mask      = 64'd0;
        hit_ready = 1'b0;

        // Reset state
        idle(3);
        check("rst_hit_valid", 160'(hit_valid), 160'd0);
        check("rst_overflow", 160'(overflow), 160'd0);
        check("rst_frame_err", 160'(frame_err), 160'd0);
        check("rst_digest", hit_digest, 160'd0);
        check("rst_index", 160'(hit_index), 160'd0);
        rst_n = 1'b1;
        idle(1);

        // mask=0, single burst, latency of exactly 6 cycles from din_first
        burst(32'd1, 32'd2, 32'd3, 32'd4, 32'd5);
        idle(2);
        check("lat_t5_valid", 160'(hit_valid), 160'd0);
        idle(1);
        check("lat_t6_valid", 160'(hit_valid), 160'd1);
        check("lat_digest", hit_digest, 160'h00000001_00000002_00000003_00000004_00000005);
        check("lat_index", 160'(hit_index), 160'd0);
        idle(2);
        check("hold_index", 160'(hit_index), 160'd0);
        hit_ready = 1'b1;
        idle(1);
        hit_ready = 1'b0;
        check("pop_empty", 160'(hit_valid), 160'd0);

        // Masked compare on the upper half of word 0
        do_reset();
        target = 64'h00000000_FFFFFFFF;
        mask   = 64'hFFFF0000_00000000;
        burst(32'h0001ABCD, 32'h11111111, 32'd3, 32'd4, 32'd5);
        burst(32'h00001234, 32'h22222222, 32'd3, 32'd4, 32'd5);
        burst(32'h0000FFFF, 32'h33333333, 32'd3, 32'd4, 32'd5);
        idle(3);
        check("mask_valid", 160'(hit_valid), 160'd1);
        check("mask_first_idx", 160'(hit_index), 160'd1);
        check("mask_first_w0", 160'(hit_digest[159:128]), 160'h00001234);
        hit_ready = 1'b1;
        idle(1);
        check("mask_second_idx", 160'(hit_index), 160'd2);
        check("mask_second_w0", 160'(hit_digest[159:128]), 160'h0000FFFF);
        idle(1);
        check("mask_drained", 160'(hit_valid), 160'd0);
        hit_ready = 1'b0;
        target = 64'd0;
        mask   = 64'd0;

        // Overflow: five back-to-back hits into a four-entry FIFO
        do_reset();
        for (int i = 0; i < 5; i++)
            burst(32'(i * 16 + 1), 32'(i * 16 + 2), 32'(i * 16 + 3), 32'(i * 16 + 4), 32'(i * 16 + 5));
        idle(3);
        check("ovf_set", 160'(overflow), 160'd1);
        hit_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("ovf_drain_idx", 160'(hit_index), 160'(k));
            idle(1);
        end
        check("ovf_drained", 160'(hit_valid), 160'd0);
        hit_ready = 1'b0;

        // Full FIFO, pop coinciding with a push
        do_reset();
        for (int i = 0; i < 4; i++)
            burst(32'(i + 100), 32'd7, 32'd8, 32'd9, 32'd10);
        burst(32'd200, 32'd7, 32'd8, 32'd9, 32'd10);
        idle(2);
        hit_ready = 1'b1;
        idle(1);
        hit_ready = 1'b0;
        check("same_cycle_ovf", 160'(overflow), 160'd0);
        check("same_cycle_head", 160'(hit_index), 160'd1);
        hit_ready = 1'b1;
        for (int k = 1; k < 5; k++) begin
            check("same_cycle_idx", 160'(hit_index), 160'(k));
            idle(1);
        end
        check("same_cycle_drained", 160'(hit_valid), 160'd0);
        hit_ready = 1'b0;

        // Framing error: aborted partial burst followed by a full one
        do_reset();
        tick(1'b1, 32'hAAAA0000);
        tick(1'b0, 32'hAAAA0001);
        tick(1'b0, 32'hAAAA0002);
        burst(32'hBBBB0000, 32'hBBBB0001, 32'hBBBB0002, 32'hBBBB0003, 32'hBBBB0004);
        idle(3);
        check("ferr_set", 160'(frame_err), 160'd1);
        check("ferr_valid", 160'(hit_valid), 160'd1);
        check("ferr_index", 160'(hit_index), 160'd0);
        check("ferr_digest", hit_digest, 160'hBBBB0000_BBBB0001_BBBB0002_BBBB0003_BBBB0004);
        hit_ready = 1'b1;
        idle(1);
        check("ferr_single_hit", 160'(hit_valid), 160'd0);
        hit_ready = 1'b0;

        // Reset during word 3, din_first right after reset release
        do_reset();
        tick(1'b1, 32'hC0);
        tick(1'b0, 32'hC1);
        tick(1'b0, 32'hC2);
        tick(1'b0, 32'hC3);
        rst_n = 1'b0;
        tick(1'b1, 32'hD0);
        rst_n = 1'b1;
        tick(1'b0, 32'hD1);
        tick(1'b0, 32'hD2);
        tick(1'b0, 32'hD3);
        tick(1'b0, 32'hD4);
        idle(3);
        check("rstmid_valid", 160'(hit_valid), 160'd1);
        check("rstmid_index", 160'(hit_index), 160'd0);
        check("rstmid_digest", hit_digest, 160'h000000D0_000000D1_000000D2_000000D3_000000D4);
        check("rstmid_ovf", 160'(overflow), 160'd0);
        check("rstmid_ferr", 160'(frame_err), 160'd0);
        hit_ready = 1'b1;
        idle(1);
        hit_ready = 1'b0;

        // Reset while a completed hit sits in the compare pipeline
        burst(32'hE0, 32'hE1, 32'hE2, 32'hE3, 32'hE4);
        idle(1);
        rst_n = 1'b0;
        idle(1);
        rst_n = 1'b1;
        idle(4);
        check("rstpipe_dropped", 160'(hit_valid), 160'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/digest_match.md
DIGEST_MATCH -- requirements
Module: digest_match

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, hit FIFO entries (power of two, >=2).
REQ-002 SHALL have parameter INDEX_W, default 32, width of burst index counter.
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port din  input  32  digest word stream from the quad SHA-1 stage (R); words E,D,C,B,A order, 0 outside bursts.
REQ-006 SHALL have port din_first  input  1  pulse marking the cycle carrying word 0 of a 5-word burst.
REQ-007 SHALL have port target  input  64  compare value for words 0..1 (word0 in [63:32]).
REQ-008 SHALL have port mask  input  64  compare mask; bit 1 = bit must equal target.
REQ-009 SHALL have port hit_valid  output  1  FIFO head holds a hit.
REQ-010 SHALL have port hit_ready  input  1  consumer accepts head when hit_valid & hit_ready.
REQ-011 SHALL have port hit_digest  output  160  captured digest, word0 in [159:128].
REQ-012 SHALL have port hit_index  output  INDEX_W  index of the burst that hit.
REQ-013 SHALL have port overflow  output  1  sticky: a hit was dropped because FIFO was full.
REQ-014 SHALL have port frame_err  output  1  sticky: din_first seen mid-burst.

Function
REQ-015 Collector SHALL have states IDLE, COLLECT(k=1..4); din_first in any state SHALL load word0 and enter COLLECT(1).
REQ-016 In COLLECT(k) without din_first, din SHALL be stored as word k; k=4 completes the burst and returns to IDLE.
REQ-017 din_first in COLLECT(1..4) SHALL abort the partial burst (no count, no compare), set frame_err, and start a new burst with the current word.
REQ-018 din in IDLE without din_first SHALL be ignored.
REQ-019 Each completed burst SHALL increment the burst counter once; counter wraps modulo 2^INDEX_W; first completed burst after reset has index 0.
REQ-020 Match SHALL be ((word0,word1) XOR target) AND mask == 0; mask=0 matches every burst.
REQ-021 target and mask SHALL be sampled in the cycle word 4 is sampled.
REQ-022 Compare SHALL be registered; a matching burst SHALL be pushed so hit_valid can rise exactly 2 cycles after the edge sampling word 4 (FIFO previously empty).
REQ-023 A push SHALL store the full 160-bit digest and the burst's index.
REQ-024 Pop SHALL occur on edge with hit_valid & hit_ready; hit_digest/hit_index SHALL stay stable while hit_valid & !hit_ready.
REQ-025 Push when full SHALL be accepted if a pop occurs the same cycle; otherwise the hit SHALL be dropped and overflow set.
REQ-026 Push and pop same cycle with 1..FIFO_DEPTH-1 entries SHALL leave occupancy unchanged, ordering preserved (FIFO order).
REQ-027 FIFO pointers SHALL wrap modulo FIFO_DEPTH; hit_valid SHALL be 0 when empty.
REQ-028 Back-to-back bursts (din_first every 5 cycles) SHALL be processed without loss apart from REQ-025.

Reset
REQ-029 rst_n low at a posedge SHALL force: collector IDLE, burst counter 0, FIFO empty, hit_valid 0, overflow 0, frame_err 0, compare pipeline cleared.
REQ-030 hit_digest and hit_index SHALL read 0 after reset until the first push.
REQ-031 Reset asserted mid-burst SHALL discard the partial burst and any hit in the compare pipeline; din_first in the first cycle after rst_n rises SHALL be honoured.

Verification
REQ-032 mask=0, one burst words 1,2,3,4,5 at din_first=cycle t -> hit_valid high at t+6, hit_digest=0x00000001_00000002_00000003_00000004_00000005, hit_index=0.
REQ-033 target=0x00000000_FFFFFFFF, mask=0xFFFF0000_00000000, three bursts with word0=0x0001ABCD, 0x00001234, 0x0000FFFF -> two hits, indices 1 and 2, in order.
REQ-034 FIFO_DEPTH=4, mask=0, hit_ready=0, 5 bursts -> 4 entries held (indices 0..3), overflow=1; then hit_ready=1 drains 0..3 and hit_valid falls.
REQ-035 din_first, 2 words, din_first again, 4 words -> frame_err=1, exactly one hit, index 0, digest from second burst only.
REQ-036 rst_n low during word 3 of a matching burst, then full burst -> only second burst reported, index 0, overflow=0, frame_err=0.
REQ-037 FIFO full with hit_ready=1 while a new hit pushes -> occupancy unchanged, overflow stays 0, new entry appears after existing ones.
